// File: rtl/cpu_ctrl_sequencer_pkg.sv
// rtl/cpu_ctrl_sequencer_pkg.sv - opcodes, T-state codes and control-word layout for the bus CPU sequencer
package cpu_ctrl_sequencer_pkg;

   localparam int OPC_W = 4;
   localparam int T_W   = 3;

   localparam logic [T_W-1:0] T0 = 3'd0;
   localparam logic [T_W-1:0] T1 = 3'd1;
   localparam logic [T_W-1:0] T2 = 3'd2;
   localparam logic [T_W-1:0] T3 = 3'd3;
   localparam logic [T_W-1:0] T4 = 3'd4;

   localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPC_W-1:0] OP_STA = 4'h4;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   localparam int CW_W       = 14;
   localparam int CW_PC_RD   = 13;
   localparam int CW_RAM_RD  = 12;
   localparam int CW_IR_RD   = 11;
   localparam int CW_A_RD    = 10;
   localparam int CW_ALU_RD  = 9;
   localparam int CW_PC_WR   = 8;
   localparam int CW_MAR_WR  = 7;
   localparam int CW_RAM_WR  = 6;
   localparam int CW_IR_WR   = 5;
   localparam int CW_A_WR    = 4;
   localparam int CW_B_WR    = 3;
   localparam int CW_OUT_WR  = 2;
   localparam int CW_PC_INC  = 1;
   localparam int CW_ALU_SUB = 0;

   typedef logic [CW_W-1:0] ctrl_word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } seq_state_e;

   function automatic ctrl_word_t cw_bit(input int idx);
      return ctrl_word_t'(1) << idx;
   endfunction

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// rtl/cpu_ctrl_sequencer_if.sv - control bus between the sequencer and the 8-bit datapath
interface cpu_ctrl_sequencer_if;
   import cpu_ctrl_sequencer_pkg::*;

   logic             run;
   logic             step;
   logic [OPC_W-1:0] opcode;
   logic             flag_c;
   logic             flag_z;

   logic pc_rd, ram_rd, ir_rd, a_rd, alu_rd;
   logic pc_wr, mar_wr, ram_wr, ir_wr, a_wr, b_wr, out_wr;
   logic pc_inc, alu_sub;
   logic [T_W-1:0]   tstate;
   logic             halted;

   modport master (
      input  run, step, opcode, flag_c, flag_z,
      output pc_rd, ram_rd, ir_rd, a_rd, alu_rd,
      output pc_wr, mar_wr, ram_wr, ir_wr, a_wr, b_wr, out_wr,
      output pc_inc, alu_sub, tstate, halted
   );

   modport slave (
      output run, step, opcode, flag_c, flag_z,
      input  pc_rd, ram_rd, ir_rd, a_rd, alu_rd,
      input  pc_wr, mar_wr, ram_wr, ir_wr, a_wr, b_wr, out_wr,
      input  pc_inc, alu_sub, tstate, halted
   );

endinterface

// File: rtl/cpu_ctrl_sequencer_ctrl_microcode_rom.sv
// rtl/cpu_ctrl_sequencer_ctrl_microcode_rom.sv - combinational micro-op table indexed by opcode and T-state
module ctrl_microcode_rom
   import cpu_ctrl_sequencer_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic [T_W-1:0]   tstate,
   input  logic             flag_c,
   input  logic             flag_z,
   output ctrl_word_t       cw,
   output logic             last,
   output logic             halt
);

   always_comb begin
      cw   = '0;
      last = 1'b0;
      halt = 1'b0;
      case (tstate)
         T0: cw = cw_bit(CW_PC_RD) | cw_bit(CW_MAR_WR);
         T1: cw = cw_bit(CW_RAM_RD) | cw_bit(CW_IR_WR) | cw_bit(CW_PC_INC);
         T2: begin
            last = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw   = cw_bit(CW_IR_RD) | cw_bit(CW_MAR_WR);
                  last = 1'b0;
               end
               OP_LDI: cw = cw_bit(CW_IR_RD) | cw_bit(CW_A_WR);
               OP_JMP: cw = cw_bit(CW_IR_RD) | cw_bit(CW_PC_WR);
               OP_JC:  if (flag_c) cw = cw_bit(CW_IR_RD) | cw_bit(CW_PC_WR);
               OP_JZ:  if (flag_z) cw = cw_bit(CW_IR_RD) | cw_bit(CW_PC_WR);
               OP_OUT: cw = cw_bit(CW_A_RD) | cw_bit(CW_OUT_WR);
               OP_HLT: halt = 1'b1;
               default: cw = '0;
            endcase
         end
         T3: begin
            last = 1'b1;
            case (opcode)
               OP_LDA: cw = cw_bit(CW_RAM_RD) | cw_bit(CW_A_WR);
               OP_ADD, OP_SUB: begin
                  cw   = cw_bit(CW_RAM_RD) | cw_bit(CW_B_WR);
                  last = 1'b0;
               end
               OP_STA: cw = cw_bit(CW_A_RD) | cw_bit(CW_RAM_WR);
               default: cw = '0;
            endcase
         end
         T4: begin
            last = 1'b1;
            if (opcode == OP_ADD || opcode == OP_SUB)
               cw = cw_bit(CW_ALU_RD) | cw_bit(CW_A_WR);
            if (opcode == OP_SUB)
               cw = cw | cw_bit(CW_ALU_SUB);
         end
         default: last = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// rtl/cpu_ctrl_sequencer.sv - fetch/execute sequencer: T-state counter, run/step/halt FSM, output gating
module cpu_ctrl_sequencer
   import cpu_ctrl_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  clr,
   cpu_ctrl_sequencer_if.master  bus
);

   seq_state_e     state, state_nx;
   logic [T_W-1:0] tstate, tstate_nx;
   logic           step_q;
   logic           step_rise;
   ctrl_word_t     rom_cw;
   ctrl_word_t     cw;
   logic           rom_last;
   logic           rom_halt;

   ctrl_microcode_rom u_rom (
      .opcode (bus.opcode),
      .tstate (tstate),
      .flag_c (bus.flag_c),
      .flag_z (bus.flag_z),
      .cw     (rom_cw),
      .last   (rom_last),
      .halt   (rom_halt)
   );

   assign step_rise = bus.step & ~step_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= ST_IDLE;
         tstate <= T0;
         step_q <= 1'b0;
      end else begin
         state  <= state_nx;
         tstate <= tstate_nx;
         step_q <= bus.step;
      end
   end

   // run is only consulted at an instruction boundary, so mid-instruction changes never truncate a micro-op
   always_comb begin
      state_nx  = state;
      tstate_nx = tstate;
      case (state)
         ST_IDLE: begin
            tstate_nx = T0;
            if (bus.run || step_rise)
               state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (rom_halt) begin
               state_nx  = ST_HALT;
               tstate_nx = T0;
            end else if (rom_last) begin
               tstate_nx = T0;
               state_nx  = bus.run ? ST_RUN : ST_IDLE;
            end else begin
               tstate_nx = tstate + T_W'(1);
            end
         end
         ST_HALT: tstate_nx = T0;
         default: begin
            state_nx  = ST_IDLE;
            tstate_nx = T0;
         end
      endcase
   end

   assign cw = (state == ST_RUN) ? rom_cw : '0;

   assign bus.pc_rd   = cw[CW_PC_RD];
   assign bus.ram_rd  = cw[CW_RAM_RD];
   assign bus.ir_rd   = cw[CW_IR_RD];
   assign bus.a_rd    = cw[CW_A_RD];
   assign bus.alu_rd  = cw[CW_ALU_RD];
   assign bus.pc_wr   = cw[CW_PC_WR];
   assign bus.mar_wr  = cw[CW_MAR_WR];
   assign bus.ram_wr  = cw[CW_RAM_WR];
   assign bus.ir_wr   = cw[CW_IR_WR];
   assign bus.a_wr    = cw[CW_A_WR];
   assign bus.b_wr    = cw[CW_B_WR];
   assign bus.out_wr  = cw[CW_OUT_WR];
   assign bus.pc_inc  = cw[CW_PC_INC];
   assign bus.alu_sub = cw[CW_ALU_SUB];
   assign bus.tstate  = tstate;
   assign bus.halted  = (state == ST_HALT);

endmodule
